// File: rtl/rv_gpio_if.sv
// rv_core data-bus slave port for the rv_gpio window: address, select, lane writes, read strobe and read data.
// Read data is registered in the peripheral and is 0 whenever the window is not read.
interface rv_gpio_if;
    logic [4:0]  adr;
    logic        cs;
    logic [3:0]  we;
    logic        re;
    logic [31:0] dw;
    logic [31:0] dr;

    modport master (output adr, cs, we, re, dw, input dr);
    modport slave  (input adr, cs, we, re, dw, output dr);
endinterface

// File: rtl/rv_gpio.sv
// rv_gpio: WIDTH-pin GPIO with atomic set/clr/tgl, pin synchroniser and edge interrupts (RV_GPIO_IRQ_EN).
// Latency: writes visible on pout/poe next cycle; dr valid one cycle after cs&&re; pin->IN SYNC_STAGES cycles.
// Backpressure: none, every access completes in one cycle with no wait states.
module rv_gpio #(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       EDGE_MODE   = 0,
    parameter logic [WIDTH-1:0]  RESET_OUT   = '0,
    parameter logic [WIDTH-1:0]  RESET_DIR   = '1
) (
    input  logic             clk,
    input  logic             reset,
    rv_gpio_if.slave         bus,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic [WIDTH-1:0] poe,
    output logic             irq
);
    localparam logic [2:0] REG_OUT   = 3'd0;
    localparam logic [2:0] REG_IN    = 3'd1;
    localparam logic [2:0] REG_DIR   = 3'd2;
    localparam logic [2:0] REG_SET   = 3'd3;
    localparam logic [2:0] REG_CLR   = 3'd4;
    localparam logic [2:0] REG_TGL   = 3'd5;
    localparam logic [2:0] REG_IE    = 3'd6;
    localparam logic [2:0] REG_IFLAG = 3'd7;

    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic [2:0]       sel;

    // Lane enables expand to a bit mask; data bits outside enabled lanes never reach a register.
    assign lane_mask = {{8{bus.we[3]}}, {8{bus.we[2]}}, {8{bus.we[1]}}, {8{bus.we[0]}}};
    assign wmask     = lane_mask[WIDTH-1:0];
    assign wbits     = bus.dw[WIDTH-1:0] & wmask;
    assign sel       = bus.adr[4:2];

    logic unused_bus;
    assign unused_bus = ^{bus.adr[1:0], bus.dw, lane_mask};

    logic [WIDTH-1:0] out_q, out_n;
    logic [WIDTH-1:0] dir_q, dir_n;

    always_comb begin
        out_n = out_q;
        dir_n = dir_q;
        if (bus.cs) begin
            case (sel)
                REG_OUT: out_n = (out_q & ~wmask) | wbits;
                REG_DIR: dir_n = (dir_q & ~wmask) | wbits;
                REG_SET: out_n = out_q | wbits;
                REG_CLR: out_n = out_q & ~wbits;
                REG_TGL: out_n = out_q ^ wbits;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= RESET_OUT;
            dir_q <= RESET_DIR;
        end else begin
            out_q <= out_n;
            dir_q <= dir_n;
        end
    end

    assign pout = out_q;
    assign poe  = dir_q;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  in_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign in_q = sync_q[SYNC_STAGES-1];

    logic [WIDTH-1:0] ie_rd;
    logic [WIDTH-1:0] iflag_rd;

`ifdef RV_GPIO_IRQ_EN
    logic [WIDTH-1:0] in_d;
    logic [WIDTH-1:0] ie_q, ie_n;
    logic [WIDTH-1:0] iflag_q, iflag_n;
    logic [WIDTH-1:0] edge_v;
    logic [WIDTH-1:0] iflag_clr;

    always_comb begin
        case (EDGE_MODE)
            0:       edge_v = in_q & ~in_d;
            1:       edge_v = ~in_q & in_d;
            default: edge_v = in_q ^ in_d;
        endcase
    end

    assign ie_n      = (bus.cs && sel == REG_IE) ? ((ie_q & ~wmask) | wbits) : ie_q;
    assign iflag_clr = (bus.cs && sel == REG_IFLAG) ? wbits : '0;
    // New edges are OR-ed in after the clear so a coincident set survives.
    assign iflag_n   = (iflag_q & ~iflag_clr) | (edge_v & ie_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_d    <= '0;
            ie_q    <= '0;
            iflag_q <= '0;
        end else begin
            in_d    <= in_q;
            ie_q    <= ie_n;
            iflag_q <= iflag_n;
        end
    end

    assign ie_rd    = ie_q;
    assign iflag_rd = iflag_q;
    assign irq      = |iflag_q;
`else
    assign ie_rd    = '0;
    assign iflag_rd = '0;
    assign irq      = 1'b0;
`endif

    logic [31:0] rd_word;
    logic [31:0] dr_q;

    always_comb begin
        rd_word = '0;
        case (sel)
            REG_OUT:   rd_word[WIDTH-1:0] = out_q;
            REG_IN:    rd_word[WIDTH-1:0] = in_q;
            REG_DIR:   rd_word[WIDTH-1:0] = dir_q;
            REG_IE:    rd_word[WIDTH-1:0] = ie_rd;
            REG_IFLAG: rd_word[WIDTH-1:0] = iflag_rd;
            default:   rd_word = '0;
        endcase
    end

    // dr drops to 0 on any cycle without a read so the bus can OR all peripherals together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dr_q <= '0;
        end else begin
            dr_q <= (bus.cs && bus.re) ? rd_word : 32'h0;
        end
    end

    assign bus.dr = dr_q;
endmodule

// File: doc/rv_gpio.md
# rv_gpio

Parametrised general-purpose I/O peripheral for the rv_core data bus, replacing the fixed 8-bit parallel port at `ffff0000`. It provides:
- WIDTH bidirectional pins with per-bit direction.
- Atomic set/clear/toggle of the output register.
- A multi-stage input synchroniser.
- Edge-triggered, per-bit maskable interrupts.

It occupies one 32-byte window and joins the OR-ed read-data bus like the other `rv_*` peripherals.

## Interface
- `WIDTH`, 8: pin count, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.
- `EDGE_MODE`, 0: interrupt edge. 0 = rising, 1 = falling, 2 = both.
- `RESET_OUT`, '0: reset value of OUT.
- `RESET_DIR`, '1: reset value of DIR (1 = output).

Ports:
- `clk`  in  1  bus/CPU clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `adr`  in  5  byte offset in window; `adr[4:2]` selects register, `adr[1:0]` ignored.
- `cs`  in  1  window select.
- `we`  in  4  byte-lane write enables.
- `re`  in  1  read enable.
- `dw`  in  32  write data.
- `dr`  out  32  read data; 0 when not selected.
- `pin`  in  WIDTH  asynchronous pad inputs.
- `pout`  out  WIDTH  output register OUT.
- `poe`  out  WIDTH  output enables (= DIR).
- `irq`  out  1  interrupt request, level.

## Operation
Register map (word offset):
- 0x00 OUT, rw.
- 0x04 IN, ro: synchronised pins.
- 0x08 DIR, rw.
- 0x0C SET, wo: OUT |= data.
- 0x10 CLR, wo: OUT &= ~data.
- 0x14 TGL, wo: OUT ^= data.
- 0x18 IE, rw.
- 0x1C IFLAG, rw1c.

Write rules:
- A write occurs when `cs && we[n]`. Only byte lanes with `we[n]`=1 are affected, for every register including SET/CLR/TGL/IFLAG.
- Bits at or above WIDTH are ignored on write and read as 0.
- Writes to IN have no effect.

Read rules:
- When `cs && re`, `dr` is loaded with the addressed register on the next edge.
- SET/CLR/TGL read 0.
- Otherwise `dr` is loaded with 0 on the next edge, so the peripheral can be OR-ed onto the bus.

Synchroniser and interrupts:
- `pin` passes through SYNC_STAGES flops; the last stage is IN. A further flop `in_d` holds the previous IN.
- Edge vector: rise = IN & ~in_d; fall = ~IN & in_d. EDGE_MODE selects rise, fall, or rise|fall.
- IFLAG[i] is set when edge[i] && IE[i].
- A write-1 to IFLAG[i] clears it. If set and clear hit the same bit in the same cycle, set wins.
- Clearing IE does not clear pending flags.
- `irq` = |IFLAG, combinational from the register.

## Timing
Reset state:
- OUT=RESET_OUT, DIR=RESET_DIR, IE=0, IFLAG=0.
- Synchroniser stages and `in_d` = 0.
- `dr`=0, `irq`=0.
- Reset mid-operation: all state returns to these values asynchronously. No edge is flagged on the first cycle after release unless the pin actually transitions from the reset value of 0.

Latencies:
- Write to OUT/DIR/SET/CLR/TGL: `pout`/`poe` change 1 cycle after the write edge.
- Read: `dr` is valid 1 cycle after `cs && re`. No wait states.
- Pin change to IN: SYNC_STAGES cycles.
- Pin change to IFLAG/`irq`: SYNC_STAGES+1 cycles.

Boundary cases:
- Pulses shorter than one clock may be missed; that is by design.
- IN reflects pad state regardless of DIR, so an output pin reads back its driven value.
- When WIDTH=32, all lanes are live. When WIDTH<8, lanes 1..3 are inert.

## Configuration
- `RV_GPIO_IRQ_EN` defined: edge detection, IE, IFLAG and `irq` are implemented as above.
- Undefined:
  - `in_d`, IE and IFLAG are not built.
  - IE/IFLAG read 0 and writes to them are ignored.
  - `irq` is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Reset: assert `reset` mid-write, WIDTH=8 → `pout`=0x00, `poe`=0xFF, `irq`=0, `dr`=0 immediately, without waiting for a clock edge.
- Byte lanes: WIDTH=16. Write OUT=0xA5A5 with `we`=0001, then read OUT → 0x00A5; `pout` updates 1 cycle after the write.
- Atomic ops: OUT=0x0F, then SET 0x30 → 0x3F, CLR 0x05 → 0x3A, TGL 0xFF → 0xC5. SET/CLR/TGL read back 0.
- Synchroniser: SYNC_STAGES=2, drive `pin`=0x81 → IN reads 0x81 only when the read is issued ≥2 cycles after the change. Out-of-window read (`cs`=0) → `dr`=0.
- Interrupt: EDGE_MODE=0, IE=0x01, rising edge on `pin[0]` → `irq`=1 after 3 cycles, IFLAG=0x01. Falling edge → no new flag. Write IFLAG=0x01 → `irq`=0. A write-1-clear in the same cycle as a new set leaves the flag=1.
- Macro off: with `RV_GPIO_IRQ_EN` undefined, toggle all pins with IE written 0xFF → `irq` stays 0, IE/IFLAG read 0.
